// File: rtl/cpu_defs.sv
// Shared CPU definitions: divider issue FSM encoding and HI/LO result layout.
package cpu_defs;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StDone  = 2'd3
    } div_state_e;

    localparam logic [31:0] ZERO_LO_DEFAULT = 32'hFFFF_FFFF;

    // Divider result is packed {remainder, quotient}.
    localparam int unsigned RES_HI_MSB = 63;
    localparam int unsigned RES_HI_LSB = 32;
    localparam int unsigned RES_LO_MSB = 31;
    localparam int unsigned RES_LO_LSB = 0;

endpackage

// File: rtl/div_issue_ctrl.sv
// EX-stage front end for the iterative divider: operand latch, start pulse, stall,
// result capture for HI/LO, flush abort, divide-by-zero and watchdog handling.
module div_issue_ctrl
    import cpu_defs::*;
#(
    parameter int unsigned TIMEOUT = 40,
    parameter logic [31:0] ZERO_LO = ZERO_LO_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ex_div_req,
    input  logic        ex_div_sign,
    input  logic [31:0] ex_src_a,
    input  logic [31:0] ex_src_b,
    input  logic        ex_advance,
    output logic        div_stall,
    output logic        res_valid,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        timeout_err,
    output logic        div_valid,
    output logic        div_sign,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        div_flush,
    input  logic        div_ready,
    input  logic [63:0] div_result
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    div_state_e  state_q, state_d;
    logic [CW-1:0] wdog_q, wdog_d, wdog_inc;
    logic        div_valid_q, div_valid_d;
    logic        div_sign_q, div_sign_d;
    logic [31:0] div_a_q, div_a_d;
    logic [31:0] div_b_q, div_b_d;
    logic        res_valid_q, res_valid_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic        timeout_q, timeout_d;

    assign wdog_inc = wdog_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        wdog_d      = wdog_q;
        div_valid_d = 1'b0;
        div_sign_d  = div_sign_q;
        div_a_d     = div_a_q;
        div_b_d     = div_b_q;
        res_valid_d = res_valid_q;
        res_hi_d    = res_hi_q;
        res_lo_d    = res_lo_q;
        timeout_d   = timeout_q;

        case (state_q)
            StIdle: begin
                if (ex_div_req && !flush) begin
                    div_sign_d = ex_div_sign;
                    div_a_d    = ex_src_a;
                    div_b_d    = ex_src_b;
                    if (ex_src_b == 32'd0) begin
                        // Divide-by-zero never reaches the divider.
                        res_hi_d    = ex_src_a;
                        res_lo_d    = ZERO_LO;
                        res_valid_d = 1'b1;
                        state_d     = StDone;
                    end else begin
                        div_valid_d = 1'b1;
                        state_d     = StIssue;
                    end
                end
            end
            StIssue: begin
                wdog_d  = '0;
                state_d = StWait;
            end
            StWait: begin
                wdog_d = wdog_inc;
                if (div_ready) begin
                    res_hi_d    = div_result[RES_HI_MSB:RES_HI_LSB];
                    res_lo_d    = div_result[RES_LO_MSB:RES_LO_LSB];
                    res_valid_d = 1'b1;
                    state_d     = StDone;
                end else if (wdog_inc == CW'(TIMEOUT)) begin
                    timeout_d   = 1'b1;
                    res_hi_d    = '0;
                    res_lo_d    = '0;
                    res_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (ex_advance) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (flush) begin
            state_d     = StIdle;
            res_valid_d = 1'b0;
            div_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            wdog_q      <= '0;
            div_valid_q <= 1'b0;
            div_sign_q  <= 1'b0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_hi_q    <= '0;
            res_lo_q    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wdog_q      <= wdog_d;
            div_valid_q <= div_valid_d;
            div_sign_q  <= div_sign_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            res_valid_q <= res_valid_d;
            res_hi_q    <= res_hi_d;
            res_lo_q    <= res_lo_d;
            timeout_q   <= timeout_d;
        end
    end

    // A flush landing on the ISSUE cycle must not start the divider.
    assign div_valid   = div_valid_q & ~flush;
    assign div_sign    = div_sign_q;
    assign div_a       = div_a_q;
    assign div_b       = div_b_q;
    assign div_flush   = flush;
    assign div_stall   = ex_div_req && (state_q != StDone);
    assign res_valid   = res_valid_q;
    assign res_hi      = res_hi_q;
    assign res_lo      = res_lo_q;
    assign timeout_err = timeout_q;

endmodule
